mtx_phase_gen_mc: RTL and testbench
===================================

Name: mtx_phase_gen_mc

Overview:
Multi-channel, runtime-programmable phase sequencer for the main ANC transmit path. It generates the stepped-chirp phase stream: per sample, the phase advances by a per-symbol increment; per symbol, the increment grows by a fixed step and the start phase shifts. The phase is emitted as an AXI-Stream, one beat per channel per sample, into the DDS sin/cos stage. Unlike the single-channel fixed-parameter generator, the phase advances only on a handshake, the configuration loads at runtime, and each channel gets its own phase offset.

Parameters:
PHASE_WIDTH, 24, phase accumulator and output width
NSYMB_WIDTH, 16, symbol counter width
NCHAN, 2, channels interleaved per sample (1..16)
CHAN_WIDTH, 1, width of the channel index (at least log2(NCHAN), minimum 1)
TX_SYNC_BITS, 3, frame counter width for the sync indication

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
srst  in  1  synchronous active-high soft reset, identical effect to reset
enable  in  1  run request
cfg_load  in  1  strobe: capture all cfg_* inputs into shadow registers
cfg_nsig  in  PHASE_WIDTH  samples per symbol
cfg_nsymb  in  NSYMB_WIDTH  symbols per frame
cfg_start_ph  in  PHASE_WIDTH  phase of sample 1, symbol 1
cfg_start_ph_inc  in  PHASE_WIDTH  per-sample increment in symbol 1
cfg_dph_inc  in  PHASE_WIDTH  increment added per symbol
cfg_nph_shift  in  PHASE_WIDTH  start phase subtracted per symbol
cfg_chan_ph_off  in  PHASE_WIDTH  phase offset between adjacent channels
out_tdata  out  PHASE_WIDTH  phase beat
out_tuser  out  CHAN_WIDTH  channel index of the beat
out_tlast  out  1  last beat of a symbol
out_tvalid  out  1  beat valid
out_tready  in  1  downstream ready
out_sof  out  1  first beat of a frame, qualified by out_tvalid
sync_ready  out  1  high throughout every 2^TX_SYNC_BITS-th frame
busy  out  1  state is not IDLE
symbN  out  NSYMB_WIDTH  current symbol, 1-based
sigN  out  PHASE_WIDTH  current sample, 1-based

Behaviour:
- Reset/srst (both synchronous, active-high):
  - state=IDLE.
  - All outputs 0; symbN=0, sigN=0.
  - Frame counter=0.
  - Shadow config = all-zero except nsig=1, nsymb=1.
- Shadow config:
  - cfg_load captures the cfg_* inputs in any state.
  - Active config copies the shadow on IDLE->RUN and at every frame wrap.
  - A load during RUN therefore takes effect from the next frame.
  - Active nsig=0 or nsymb=0 is treated as 1.
- States IDLE, RUN, STOP:
  - IDLE: out_tvalid=0. When enable is sampled high, load the active config, set n=1, k=1, c=0, phase=start_ph, inc=start_ph_inc, sph=start_ph, and go to RUN. The first beat is valid on the next cycle.
  - RUN: out_tvalid=1. State advances only on a handshake (out_tvalid & out_tready). While stalled, tdata, tuser, tlast and sof stay constant.
  - STOP: entered from RUN when enable is sampled low. Beats continue until the handshake of the current symbol's tlast, then go to IDLE. Re-asserting enable in STOP has no effect. If enable is low on the tlast handshake while in RUN, go directly to IDLE.
- Beat content:
  - out_tdata = phase + c*chan_ph_off, modulo 2^PHASE_WIDTH. Compute it incrementally: add chan_ph_off per channel step; no multiplier.
  - out_tuser = c.
  - out_tlast = (n==nsig && c==NCHAN-1).
  - out_sof = (n==1 && k==1 && c==0).
- Advance on handshake:
  - If c<NCHAN-1: c+1.
  - Else if n<nsig: c=0, n+1, phase += inc.
  - Else, symbol end:
    - If k<nsymb: k+1, n=1, inc += dph_inc, sph -= nph_shift, phase = the new sph.
    - Else, frame wrap: k=1, n=1, reload the config, phase = sph = start_ph, inc = start_ph_inc, frame counter +1.
- Arithmetic: all phase arithmetic wraps modulo 2^PHASE_WIDTH; no saturation.
- sync_ready = (frame counter == all ones). It changes only at frame wrap.
- Simultaneous events: reset/srst overrides everything. cfg_load on the same cycle as a frame-wrap handshake: the new value is captured in the shadow, and the active config takes the old shadow.

Test Plan:
- Basic: NCHAN=2, nsig=4, nsymb=2, start_ph=0, start_ph_inc=0x100, dph_inc=0x100, nph_shift=0, chan_ph_off=0x800000, tready=1.
  - Symbol 1 ch0 = 0, 0x100, 0x200, 0x300; ch1 = ch0+0x800000.
  - Symbol 2 ch0 = 0, 0x200, 0x400, 0x600.
  - tlast on beats 8 and 16; sof on beats 1 and 17.
  - Beat 17 repeats beat 1.
- Backpressure: same config, random tready at 50% -> identical beat sequence; outputs stable on every stalled cycle; no beat dropped or duplicated.
- Shift wrap: nph_shift=0x10 -> symbol 2 starts at 0xFFFFF0 and steps 0x200 (0xFFFFF0, 0x0001F0, ...); the next frame's symbol 1 restarts at 0.
- Sync: TX_SYNC_BITS=2, nsymb=1, nsig=2 -> sync_ready high for exactly frames 3, 7 and 11 (0-based), low otherwise.
- Enable/config:
  - Drop enable at n=2 of symbol 1 -> beats continue through tlast, then tvalid=0 and busy=0 the next cycle.
  - cfg_load of start_ph_inc=0x40 mid-frame -> applied only from the next frame's first beat.
- srst mid-symbol under stall -> next cycle tvalid=0, symbN=0, sigN=0; a restart begins at sof with start_ph.

Source files
------------

// File: rtl/mtx_phase_gen_mc.sv
// Multi-channel stepped-chirp phase sequencer.
// Emits one AXI-Stream phase beat per channel per sample. The per-sample
// increment grows each symbol and the symbol start phase shifts down each
// symbol. Configuration is double-buffered: cfg_load fills a shadow set,
// and the active set copies the shadow on start and at every frame wrap.
//
// Handshake: a beat transfers on a rising clk edge where out_tvalid and
// out_tready are both high. out_tvalid never depends on out_tready, and
// while out_tvalid is high without out_tready the beat fields
// (tdata/tuser/tlast/sof) hold their values.
module mtx_phase_gen_mc #(
    parameter int PHASE_WIDTH  = 24,
    parameter int NSYMB_WIDTH  = 16,
    parameter int NCHAN        = 2,
    parameter int CHAN_WIDTH   = 1,
    parameter int TX_SYNC_BITS = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   srst,
    input  logic                   enable,
    input  logic                   cfg_load,
    input  logic [PHASE_WIDTH-1:0] cfg_nsig,
    input  logic [NSYMB_WIDTH-1:0] cfg_nsymb,
    input  logic [PHASE_WIDTH-1:0] cfg_start_ph,
    input  logic [PHASE_WIDTH-1:0] cfg_start_ph_inc,
    input  logic [PHASE_WIDTH-1:0] cfg_dph_inc,
    input  logic [PHASE_WIDTH-1:0] cfg_nph_shift,
    input  logic [PHASE_WIDTH-1:0] cfg_chan_ph_off,
    output logic [PHASE_WIDTH-1:0] out_tdata,
    output logic [CHAN_WIDTH-1:0]  out_tuser,
    output logic                   out_tlast,
    output logic                   out_tvalid,
    input  logic                   out_tready,
    output logic                   out_sof,
    output logic                   sync_ready,
    output logic                   busy,
    output logic [NSYMB_WIDTH-1:0] symbN,
    output logic [PHASE_WIDTH-1:0] sigN
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_STOP = 2'd2;

    localparam logic [CHAN_WIDTH-1:0]  LAST_CHAN = CHAN_WIDTH'(NCHAN - 1);
    localparam logic [PHASE_WIDTH-1:0] ONE_SIG   = PHASE_WIDTH'(1);
    localparam logic [NSYMB_WIDTH-1:0] ONE_SYMB  = NSYMB_WIDTH'(1);

    logic [1:0] state;

    // Shadow configuration, written by cfg_load
    logic [PHASE_WIDTH-1:0] sh_nsig;
    logic [NSYMB_WIDTH-1:0] sh_nsymb;
    logic [PHASE_WIDTH-1:0] sh_start_ph;
    logic [PHASE_WIDTH-1:0] sh_start_ph_inc;
    logic [PHASE_WIDTH-1:0] sh_dph_inc;
    logic [PHASE_WIDTH-1:0] sh_nph_shift;
    logic [PHASE_WIDTH-1:0] sh_chan_ph_off;

    // Active configuration used by the running frame
    logic [PHASE_WIDTH-1:0] act_nsig;
    logic [NSYMB_WIDTH-1:0] act_nsymb;
    logic [PHASE_WIDTH-1:0] act_dph_inc;
    logic [PHASE_WIDTH-1:0] act_nph_shift;
    logic [PHASE_WIDTH-1:0] act_chan_ph_off;

    // Sequencer position and phase accumulators
    logic [PHASE_WIDTH-1:0]  n;
    logic [NSYMB_WIDTH-1:0]  k;
    logic [CHAN_WIDTH-1:0]   c;
    logic [PHASE_WIDTH-1:0]  phase;
    logic [PHASE_WIDTH-1:0]  inc;
    logic [PHASE_WIDTH-1:0]  sph;
    logic [PHASE_WIDTH-1:0]  beat_ph;
    logic [TX_SYNC_BITS-1:0] frame_cnt;

    logic                   running;
    logic                   hs;
    logic                   last_chan;
    logic                   last_samp;
    logic                   last_symb;
    logic                   symb_end;
    logic [PHASE_WIDTH-1:0] sh_nsig_eff;
    logic [NSYMB_WIDTH-1:0] sh_nsymb_eff;
    logic [PHASE_WIDTH-1:0] next_sph;
    logic [PHASE_WIDTH-1:0] next_phase;

    // Position decode and zero-as-one normalisation of the counts
    always_comb begin
        running      = (state != ST_IDLE);
        hs           = running & out_tready;
        last_chan    = (c == LAST_CHAN);
        last_samp    = (n == act_nsig);
        last_symb    = (k == act_nsymb);
        symb_end     = last_chan & last_samp;
        sh_nsig_eff  = (sh_nsig == '0) ? ONE_SIG : sh_nsig;
        sh_nsymb_eff = (sh_nsymb == '0) ? ONE_SYMB : sh_nsymb;
        next_sph     = sph - act_nph_shift;
        next_phase   = phase + inc;
    end

    // Shadow load, FSM and phase sequencing
    always_ff @(posedge clk) begin
        if (reset || srst) begin
            state           <= ST_IDLE;
            sh_nsig         <= ONE_SIG;
            sh_nsymb        <= ONE_SYMB;
            sh_start_ph     <= '0;
            sh_start_ph_inc <= '0;
            sh_dph_inc      <= '0;
            sh_nph_shift    <= '0;
            sh_chan_ph_off  <= '0;
            act_nsig        <= ONE_SIG;
            act_nsymb       <= ONE_SYMB;
            act_dph_inc     <= '0;
            act_nph_shift   <= '0;
            act_chan_ph_off <= '0;
            n               <= '0;
            k               <= '0;
            c               <= '0;
            phase           <= '0;
            inc             <= '0;
            sph             <= '0;
            beat_ph         <= '0;
            frame_cnt       <= '0;
        end else begin
            if (cfg_load) begin
                sh_nsig         <= cfg_nsig;
                sh_nsymb        <= cfg_nsymb;
                sh_start_ph     <= cfg_start_ph;
                sh_start_ph_inc <= cfg_start_ph_inc;
                sh_dph_inc      <= cfg_dph_inc;
                sh_nph_shift    <= cfg_nph_shift;
                sh_chan_ph_off  <= cfg_chan_ph_off;
            end

            case (state)
                ST_IDLE: begin
                    if (enable) begin
                        act_nsig        <= sh_nsig_eff;
                        act_nsymb       <= sh_nsymb_eff;
                        act_dph_inc     <= sh_dph_inc;
                        act_nph_shift   <= sh_nph_shift;
                        act_chan_ph_off <= sh_chan_ph_off;
                        n               <= ONE_SIG;
                        k               <= ONE_SYMB;
                        c               <= '0;
                        phase           <= sh_start_ph;
                        sph             <= sh_start_ph;
                        beat_ph         <= sh_start_ph;
                        inc             <= sh_start_ph_inc;
                        state           <= ST_RUN;
                    end
                end

                ST_RUN, ST_STOP: begin
                    if (state == ST_RUN && !enable) begin
                        state <= ST_STOP;
                    end
                    if (hs) begin
                        if (!last_chan) begin
                            // Next channel of the same sample
                            c       <= c + 1'b1;
                            beat_ph <= beat_ph + act_chan_ph_off;
                        end else if (!last_samp) begin
                            // Next sample of the same symbol
                            c       <= '0;
                            n       <= n + 1'b1;
                            phase   <= next_phase;
                            beat_ph <= next_phase;
                        end else if (!last_symb) begin
                            // Next symbol: steeper increment, shifted start
                            c       <= '0;
                            n       <= ONE_SIG;
                            k       <= k + 1'b1;
                            inc     <= inc + act_dph_inc;
                            sph     <= next_sph;
                            phase   <= next_sph;
                            beat_ph <= next_sph;
                        end else begin
                            // Frame wrap: pick up the shadow configuration
                            act_nsig        <= sh_nsig_eff;
                            act_nsymb       <= sh_nsymb_eff;
                            act_dph_inc     <= sh_dph_inc;
                            act_nph_shift   <= sh_nph_shift;
                            act_chan_ph_off <= sh_chan_ph_off;
                            c               <= '0;
                            n               <= ONE_SIG;
                            k               <= ONE_SYMB;
                            phase           <= sh_start_ph;
                            sph             <= sh_start_ph;
                            beat_ph         <= sh_start_ph;
                            inc             <= sh_start_ph_inc;
                            frame_cnt       <= frame_cnt + 1'b1;
                        end
                        // Stopping always completes the current symbol first
                        if (symb_end && (state == ST_STOP || !enable)) begin
                            state   <= ST_IDLE;
                            n       <= '0;
                            k       <= '0;
                            c       <= '0;
                            beat_ph <= '0;
                        end
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

    // Output mapping; beat flags are gated so IDLE shows all zeros
    always_comb begin
        out_tvalid = running;
        busy       = running;
        out_tdata  = beat_ph;
        out_tuser  = c;
        out_tlast  = running & symb_end;
        out_sof    = running & (n == ONE_SIG) & (k == ONE_SYMB) & (c == '0);
        sync_ready = &frame_cnt;
        symbN      = k;
        sigN       = n;
    end

endmodule

// File: tb/tb_mtx_phase_gen_mc.sv
// Testbench for mtx_phase_gen_mc: directed steps with random backpressure
// and a random-configuration run, all beats compared against a closed-form
// phase model.
module tb_mtx_phase_gen_mc;

  localparam int PWID = 24;
  localparam int SWID = 16;
  localparam int NCH = 2;
  localparam int CWID = 1;
  localparam int SYNC_BITS = 2;
  // packed beat: sof, tlast, tuser, tdata, symbN, sigN, sync_ready
  localparam int PW = 1 + 1 + CWID + PWID + SWID + PWID + 1;

  logic clk = 1'b0;
  logic reset, srst, enable, cfg_load, out_tready;
  logic [PWID-1:0] cfg_nsig, cfg_start_ph, cfg_start_ph_inc;
  logic [PWID-1:0] cfg_dph_inc, cfg_nph_shift, cfg_chan_ph_off;
  logic [SWID-1:0] cfg_nsymb;
  logic [PWID-1:0] out_tdata;
  logic [CWID-1:0] out_tuser;
  logic out_tlast, out_tvalid, out_sof, sync_ready, busy;
  logic [SWID-1:0] symbN;
  logic [PWID-1:0] sigN;

  mtx_phase_gen_mc #(
    .PHASE_WIDTH(PWID), .NSYMB_WIDTH(SWID), .NCHAN(NCH),
    .CHAN_WIDTH(CWID), .TX_SYNC_BITS(SYNC_BITS)
  ) dut (
    .clk(clk), .reset(reset), .srst(srst), .enable(enable), .cfg_load(cfg_load),
    .cfg_nsig(cfg_nsig), .cfg_nsymb(cfg_nsymb), .cfg_start_ph(cfg_start_ph),
    .cfg_start_ph_inc(cfg_start_ph_inc), .cfg_dph_inc(cfg_dph_inc),
    .cfg_nph_shift(cfg_nph_shift), .cfg_chan_ph_off(cfg_chan_ph_off),
    .out_tdata(out_tdata), .out_tuser(out_tuser), .out_tlast(out_tlast),
    .out_tvalid(out_tvalid), .out_tready(out_tready), .out_sof(out_sof),
    .sync_ready(sync_ready), .busy(busy), .symbN(symbN), .sigN(sigN)
  );

  // clock
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  logic [PW-1:0] exp_q[$];

  // model configuration and frame number
  int m_nsig, m_nsymb, m_frame;
  logic [PWID-1:0] m_start, m_inc, m_dph, m_shift, m_off;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [PW-1:0] obs_pack();
    return {out_sof, out_tlast, out_tuser, out_tdata, symbN, sigN, sync_ready};
  endfunction

  // Closed-form model: phase(k,n,c) = start - k*shift + n*(inc + k*dph) + c*off
  task automatic push_frames(input int nf);
    for (int f = 0; f < nf; f++) begin
      for (int k = 0; k < m_nsymb; k++) begin
        for (int n = 0; n < m_nsig; n++) begin
          for (int c = 0; c < NCH; c++) begin
            logic [63:0] ph;
            logic sof, last, sync;
            ph = 64'(m_start) - 64'(k) * 64'(m_shift)
                 + 64'(n) * (64'(m_inc) + 64'(k) * 64'(m_dph))
                 + 64'(c) * 64'(m_off);
            sof = (k == 0 && n == 0 && c == 0);
            last = (n == m_nsig - 1 && c == NCH - 1);
            sync = ((m_frame % (1 << SYNC_BITS)) == (1 << SYNC_BITS) - 1);
            exp_q.push_back({sof, last, CWID'(c), ph[PWID-1:0], SWID'(k + 1),
                             PWID'(n + 1), sync});
          end
        end
      end
      m_frame++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; enable = 1'b0; out_tready = 1'b0; cfg_load = 1'b0; srst = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    m_frame = 0;
  endtask

  task automatic set_model(input int nsig, input int nsymb, input logic [PWID-1:0] start,
                           input logic [PWID-1:0] inc, input logic [PWID-1:0] dph,
                           input logic [PWID-1:0] shift, input logic [PWID-1:0] off);
    m_nsig = nsig; m_nsymb = nsymb; m_start = start; m_inc = inc;
    m_dph = dph; m_shift = shift; m_off = off;
  endtask

  // drive model config onto cfg_* and strobe cfg_load for one cycle
  task automatic load_cfg();
    @(negedge clk);
    cfg_nsig = PWID'(m_nsig); cfg_nsymb = SWID'(m_nsymb);
    cfg_start_ph = m_start; cfg_start_ph_inc = m_inc; cfg_dph_inc = m_dph;
    cfg_nph_shift = m_shift; cfg_chan_ph_off = m_off;
    cfg_load = 1'b1;
    @(negedge clk);
    cfg_load = 1'b0;
  endtask

  // Consume nbeats handshakes with random readiness; every valid cycle is
  // compared against the queue head, so stalled beats must hold their value.
  task automatic consume(input string tag, input int nbeats, input int ready_pct);
    int got = 0;
    int cyc = 0;
    while (got < nbeats && cyc < 4000) begin
      @(negedge clk);
      out_tready = ($urandom_range(99) < ready_pct);
      if (out_tvalid) begin
        if (exp_q.size() == 0) begin
          check({tag, "_extra_beat"}, 128'(1), 128'(0));
        end else begin
          check(tag, 128'(obs_pack()), 128'(exp_q[0]));
          if (out_tready) begin
            void'(exp_q.pop_front());
            got++;
          end
        end
      end
      cyc++;
    end
    if (got < nbeats) check({tag, "_timeout"}, 128'(got), 128'(nbeats));
    @(negedge clk);
    out_tready = 1'b0;
  endtask

  initial begin
    reset = 1'b1; srst = 1'b0; enable = 1'b0; cfg_load = 1'b0; out_tready = 1'b0;
    cfg_nsig = '0; cfg_nsymb = '0; cfg_start_ph = '0; cfg_start_ph_inc = '0;
    cfg_dph_inc = '0; cfg_nph_shift = '0; cfg_chan_ph_off = '0;
    m_frame = 0;
    repeat (2) @(negedge clk);

    // reset state
    do_reset();
    check("rst_tvalid", 128'(out_tvalid), 128'(0));
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_symbN", 128'(symbN), 128'(0));
    check("rst_sigN", 128'(sigN), 128'(0));
    check("rst_tdata", 128'(out_tdata), 128'(0));
    check("rst_flags", 128'({out_sof, out_tlast, sync_ready}), 128'(0));

    // basic: two frames, always ready (second frame repeats the first)
    set_model(4, 2, 24'h0, 24'h100, 24'h100, 24'h0, 24'h800000);
    load_cfg();
    check("idle_before_en", 128'(out_tvalid), 128'(0));
    enable = 1'b1;
    push_frames(2);
    consume("basic", 32, 100);

    // backpressure: same config, 50% ready
    do_reset();
    load_cfg();
    enable = 1'b1;
    push_frames(2);
    consume("bp", 32, 50);

    // start-phase shift wraps below zero
    do_reset();
    set_model(4, 2, 24'h0, 24'h100, 24'h100, 24'h10, 24'h800000);
    load_cfg();
    enable = 1'b1;
    push_frames(2);
    consume("shift", 32, 70);

    // sync indication over 13 short frames
    do_reset();
    set_model(2, 1, 24'h1000, 24'h20, 24'h0, 24'h0, 24'h333);
    load_cfg();
    enable = 1'b1;
    push_frames(13);
    consume("sync", 13 * 4, 100);

    // enable dropped at sample 2 of symbol 1
    do_reset();
    set_model(4, 2, 24'h0, 24'h100, 24'h100, 24'h0, 24'h800000);
    load_cfg();
    enable = 1'b1;
    push_frames(1);
    consume("stop_pre", 2, 100);
    enable = 1'b0;
    @(negedge clk);
    check("stop_busy", 128'(busy), 128'(1));
    check("stop_tvalid", 128'(out_tvalid), 128'(1));
    consume("stop_tail", 6, 100);
    check("stop_idle_tvalid", 128'(out_tvalid), 128'(0));
    check("stop_idle_busy", 128'(busy), 128'(0));
    exp_q.delete();

    // cfg_load mid-frame takes effect from the next frame
    do_reset();
    set_model(4, 2, 24'h0, 24'h100, 24'h100, 24'h0, 24'h800000);
    load_cfg();
    enable = 1'b1;
    push_frames(1);
    m_inc = 24'h40;
    push_frames(1);
    consume("cfg_mid_a", 5, 100);
    cfg_start_ph_inc = 24'h40;
    cfg_load = 1'b1;
    @(negedge clk);
    cfg_load = 1'b0;
    consume("cfg_mid_b", 27, 100);

    // srst while stalled mid-symbol, then restart
    do_reset();
    set_model(4, 2, 24'h0, 24'h100, 24'h100, 24'h0, 24'h800000);
    load_cfg();
    enable = 1'b1;
    push_frames(1);
    consume("srst_pre", 3, 100);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("srst_stall_hold", 128'(obs_pack()), 128'(exp_q[0]));
    end
    srst = 1'b1;
    enable = 1'b0;
    @(negedge clk);
    srst = 1'b0;
    check("srst_tvalid", 128'(out_tvalid), 128'(0));
    check("srst_busy", 128'(busy), 128'(0));
    check("srst_symbN", 128'(symbN), 128'(0));
    check("srst_sigN", 128'(sigN), 128'(0));
    exp_q.delete();
    m_frame = 0;
    set_model(4, 2, 24'h123456, 24'h100, 24'h100, 24'h0, 24'h800000);
    load_cfg();
    enable = 1'b1;
    push_frames(1);
    consume("srst_restart", 16, 100);

    // random configurations, random backpressure
    for (int t = 0; t < 4; t++) begin
      do_reset();
      set_model($urandom_range(5, 1), $urandom_range(3, 1),
                PWID'($urandom), PWID'($urandom), PWID'($urandom),
                PWID'($urandom), PWID'($urandom));
      load_cfg();
      enable = 1'b1;
      push_frames(2);
      consume("rand", 2 * m_nsig * m_nsymb * NCH, 60);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
